// File: rtl/pipeline_pkg.sv
// Shared types and constants for the memory port arbiter.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

    localparam int unsigned DEFAULT_MEM_LAT = 1;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter, master the environment.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_read;
    logic              dm_write;
    logic              dm_lb;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_lb, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, stall, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_lb, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, stall, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/byte_load_ext.sv
// Load result formatting: sign-extended byte for lb, word passthrough otherwise.
module byte_load_ext (
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic        lb,
    output logic [31:0] result
);
    logic [7:0] lane_byte;

    always_comb begin
        unique case (addr)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
        result = lb ? {{24{lane_byte[7]}}, lane_byte} : word;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between instruction fetch and data access.
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = DEFAULT_MEM_LAT
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

    arb_state_t        state;
    grant_t            grant;
    grant_t            last_grant;
    grant_t            pick;
    logic              we;
    logic              lb;
    logic [1:0]        lane;
    logic [CNT_W-1:0]  cnt;
    logic              dm_req;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] load_data;

    assign dm_req    = bus.dm_read | bus.dm_write;
    assign bus.stall = (bus.if_req & ~bus.if_ready) | (dm_req & ~bus.dm_ready);

    // Data wins a tie unless it was the one served last
    always_comb begin
        pick = GRANT_IF;
        if (dm_req && (!bus.if_req || last_grant == GRANT_IF)) pick = GRANT_DM;
        req_addr = (pick == GRANT_DM) ? bus.dm_addr : bus.if_addr;
    end

    byte_load_ext u_ext (
        .word   (bus.mem_rdata),
        .addr   (lane),
        .lb     (lb),
        .result (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            grant         <= GRANT_IF;
            last_grant    <= GRANT_IF;
            we            <= 1'b0;
            lb            <= 1'b0;
            lane          <= '0;
            cnt           <= '0;
            bus.if_ready  <= 1'b0;
            bus.dm_ready  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Memory strobes are registered, so they are loaded on entry to ACCESS
                    if (bus.if_req || dm_req) begin
                        grant         <= pick;
                        we            <= (pick == GRANT_DM) && bus.dm_write;
                        lb            <= (pick == GRANT_DM) && bus.dm_read && !bus.dm_write && bus.dm_lb;
                        lane          <= req_addr[1:0];
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= (pick == GRANT_DM) && bus.dm_write;
                        bus.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_wdata <= bus.dm_wdata;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    cnt        <= LAT;
                    state      <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (grant == GRANT_IF) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ready <= 1'b1;
                        end else begin
                            bus.dm_rdata <= we ? '0 : load_data;
                            bus.dm_ready <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    bus.if_ready <= 1'b0;
                    bus.dm_ready <= 1'b0;
                    last_grant   <= grant;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port, fixed-latency unified memory between the pipeline's instruction-fetch stage and its MEM-stage data access. The MEM-stage request comes straight from the decoder's MemRead/MemWrite/is_lb controls. The block sequences each access through a small state machine and returns a one-cycle ready pulse to the winning requester. It also drives a global `stall` to the hazard logic while any request is outstanding.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width (fixed at 32 for lb lane select)
- `MEM_LAT`, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `if_req`  in  1  fetch request, level, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address (word aligned)
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_ready`
- `if_ready`  out  1  one-cycle completion pulse for fetch
- `dm_read`  in  1  MemRead from decoder, level
- `dm_write`  in  1  MemWrite from decoder, level
- `dm_lb`  in  1  is_lb from decoder; byte load when `dm_read`=1
- `dm_addr`  in  ADDR_W  data byte address
- `dm_wdata`  in  DATA_W  store data (word store only)
- `dm_rdata`  out  DATA_W  load result, sign-extended byte if lb; valid with `dm_ready`
- `dm_ready`  out  1  one-cycle completion pulse for data
- `stall`  out  1  any requester waiting
- `mem_en`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`  out  ADDR_W  word address (`addr[1:0]` forced 0)
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- **IDLE:** sample requests. The data request is `dm_read|dm_write`.
  - If only one request is present, grant it.
  - If both are present, grant the one not served last (`last_grant` register). After reset `last_grant`=IF, so data wins the first tie.
  - On a grant, register `grant`, `we` (`dm_write`, data only), `lb`, `addr` and `wdata`, then go to ACCESS.
- **ACCESS:** exactly one cycle. `mem_en`=1; `mem_we`=the registered `we`; `mem_addr`/`mem_wdata` come from the latched values. Load counter with MEM_LAT and go to WAIT.
- **WAIT:** MEM_LAT cycles. The counter decrements each cycle. In the cycle where the counter is 1, capture `mem_rdata` into the response register and go to RESP.
- **RESP:** one cycle.
  - Pulse `if_ready` or `dm_ready` according to `grant`. Update `last_grant`, then return to IDLE.
  - For a data load with lb: select byte `addr[1:0]` (little-endian, lane 0 = bits 7:0) and sign-extend to 32 bits.
  - For a store: `dm_rdata` is 0.
- **Outputs outside ACCESS:** `mem_en`=`mem_we`=0. `mem_addr` and `mem_wdata` hold their last value.
- **Stall:** `stall` = (`if_req` & ~`if_ready`) | ((`dm_read`|`dm_write`) & ~`dm_ready`). It is combinational from inputs and registered ready.
- **Illegal and ignored inputs:**
  - `dm_read` & `dm_write` together is illegal; write wins and a single ready pulse is issued.
  - `dm_lb` without `dm_read` is ignored.
- **Request sampling:** requests are sampled only in IDLE. A request withdrawn after its grant still completes and still pulses ready.
- **Reset:** asynchronous assert forces IDLE, counter 0, `last_grant`=IF, and all outputs 0 (`if_ready`, `dm_ready`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`). An in-flight access is abandoned; a write already strobed is not undone. Release is sampled on the next rising edge.

## Timing
- Request present in IDLE cycle t: ACCESS at t+1, WAIT at t+2..t+1+MEM_LAT, ready at t+2+MEM_LAT.
- For MEM_LAT=1, ready comes 3 cycles after the request.
- Memory contract: `mem_rdata` is valid MEM_LAT cycles after the `mem_en` cycle.
- RESP always returns to IDLE, so there is one access per MEM_LAT+3 cycles. The requester updates its request on the ready edge, and IDLE sees the new value.
- Both requests pending with MEM_LAT=1: data ready at t+3 and fetch ready at t+7. `stall` stays high from t to t+6 and falls at t+7 (same cycle as `if_ready`).
- Counter width: 4 bits.

## Structure
- Shared package `pipeline_pkg`: state enum (IDLE/ACCESS/WAIT/RESP), grant encoding (GRANT_IF=0, GRANT_DM=1), default MEM_LAT.
- One sub-module: `byte_load_ext` (combinational). Inputs `word`, `addr[1:0]`, `lb`; output is the 32-bit result, the sign-extended byte when `lb`=1 and the word passthrough otherwise.

## Test plan
- **Single fetch:** `if_req`=1, addr 0x0040_0004, memory returns 0x2008_0005 (MEM_LAT=1).
  - ACCESS one cycle later with `mem_addr`=0x0040_0004, `mem_we`=0.
  - `if_ready`=1 with `if_rdata`=0x2008_0005 three cycles after the request; `stall` falls that same cycle.
- **lb sign-extension:** `dm_read`=`dm_lb`=1, addr 0x1000_0003, word 0x80FF_7F01.
  - `dm_rdata`=0xFFFF_FF80; `mem_addr`=0x1000_0000.
  - Same word with addr …0 gives 0x0000_0001.
- **Simultaneous requests after reset:** data served first, fetch next. Ready pulses at t+3 (dm) and t+7 (if); exactly one `mem_en` per access.
- **Store then tie:** sw of 0xDEAD_BEEF to 0x1000_0010 drives `mem_we`=1 for exactly one cycle and `dm_ready` with `dm_rdata`=0. With both requests pending next, IF wins (round-robin).
- **MEM_LAT=4 with reset mid-WAIT:**
  - Without reset, ready comes at t+6.
  - Assert `reset` at t+3: all outputs 0 immediately. After release, a new fetch completes normally with no stale ready.
- **Illegal `dm_read`+`dm_write`:** treated as a write, with one `dm_ready` pulse.
